mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4-input 16-bit MUX between four requesters and one downstream consumer.
- Each requester presents a req bit plus data on its MUX input. The arbiter drives the MUX select and forwards the selected word with a valid/ready handshake.
- It returns a one-cycle ack to the requester whose word was accepted.
- It sits in the RISC datapath wherever several sources contend for one 16-bit bus, such as writeback or operand forwarding.

Parameters:
- WIDTH, 16, data width of in1..in4 and out_data; must match the MUX instance.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i corresponds to in(i+1).
- in1  input  WIDTH  requester 0 data; held stable while req[0]=1.
- in2  input  WIDTH  requester 1 data.
- in3  input  WIDTH  requester 2 data.
- in4  input  WIDTH  requester 3 data.
- out_ready  input  1  consumer ready.
- select  output  2  registered MUX select; equals index of the current grant.
- gnt  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  combinational; ack[i] = out_valid & out_ready & gnt[i].
- out_data  output  WIDTH  MUX output for the current select.
- out_valid  output  1  registered; selected word is valid.
- xfer_cnt  output  CNT_W  count of completed handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of state or in-flight transfer):
  - select=0, gnt=0, out_valid=0, xfer_cnt=0, ptr=0, state=IDLE.
  - ack is therefore 0 the following cycle.
  - Any in-flight word is dropped without ack.
- ptr (2 bits) is the highest-priority index. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- State IDLE:
  - If req != 0, pick the winner w, the first set bit in priority order.
  - Next cycle: gnt=onehot(w), select=w, out_valid=1, state=BUSY.
  - If req == 0, outputs hold idle values.
  - Grant latency: req rising to out_valid is 1 cycle.
- State BUSY:
  - Handshake (out_valid & out_ready):
    - ack[select] pulses this cycle; xfer_cnt increments; ptr <= select+1.
    - Re-arbitrate in the same cycle using the current req vector and the new ptr (select+1).
    - If any req is set, load the new winner and stay BUSY with out_valid=1. This gives back-to-back transfers, one word per cycle.
    - Otherwise clear gnt and out_valid and go to IDLE.
    - The just-served requester may keep req high and competes at lowest priority.
  - Abort (req[select]=0 and no handshake):
    - No ack, no count.
    - ptr <= select+1; gnt and out_valid clear; state IDLE next cycle.
  - Stall (out_ready=0 and req[select]=1): hold select, gnt and out_valid unchanged. The grant is never preempted by other requests.
- Simultaneous handshake and req[select] falling: the handshake wins; ack is issued and the word is counted.
- out_data is purely combinational through the MUX. The arbiter never registers data; requesters must hold data until ack.
- xfer_cnt wrap: 0xFFFF + 1 -> 0x0000 with no flag.
- Invariants: out_valid == |gnt; gnt is always one-hot or zero; gnt[select]==1 whenever out_valid.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=1'b0, BUSY=1'b1.
  - Requester count constant N_REQ=4.
  - Select width SEL_W=2.
- One sub-module: the existing MUX, instantiated once with select, in1..in4, out.
- The round-robin pick function stays inline in the arbiter; it is a function, not a module.

Test Plan:
- Reset / idle: rst high 2 cycles with req=4'b1111, then low, in1..in4=11111, 22222, 33333, 44444, out_ready=1.
  - During and 1 cycle after reset: out_valid=0, gnt=0, xfer_cnt=0.
  - Then grants in order 0,1,2,3,0: out_data 11111, 22222, 33333, 44444, 11111 on consecutive cycles.
- Single requester: req=4'b0100 for 1 cycle, out_ready=1.
  - Next cycle: select=2, out_data=33333, ack=4'b0100.
  - Following cycle: out_valid=0, ptr=3.
- Backpressure: req=4'b0011, out_ready=0 for 5 cycles, then 1.
  - select stays 0 and out_data stays 11111 for 5 cycles with ack=0.
  - Then ack[0], then select=1 and ack[1]; xfer_cnt=2.
- Abort: grant requester 3, out_ready=0, then drop req[3] with req[1]=1.
  - No ack[3]; IDLE for 1 cycle; then select=1, out_valid=1; xfer_cnt unchanged.
- Reset mid-operation: assert rst while BUSY stalled on requester 2.
  - Next cycle: out_valid=0, gnt=0, ptr=0.
  - After release with req=4'b1100: grant goes to 2 (first set bit from ptr=0), not 3.
- Counter wrap: force 65536 back-to-back handshakes with req=4'b0001 held and out_ready=1.
  - xfer_cnt returns to 0; throughput is one ack per cycle throughout.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin MUX arbiter.
// No logic; imported by the arbiter top and its MUX.
// Requester count and select width are fixed by the 4-input MUX.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// 4-input WIDTH-bit multiplexer steered by a 2-bit select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output simply follows select and the inputs.
module mux_rr_arbiter_mux
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [SEL_W-1:0] select,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        case (select)
            2'd0:    out = in1;
            2'd1:    out = in2;
            2'd2:    out = in3;
            default: out = in4;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit MUX between four requesters.
// Latency: request to out_valid is 1 cycle; back-to-back grants give one word per cycle.
// Backpressure: out_ready low holds the current grant; it is never preempted.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             out_ready,
    output logic [SEL_W-1:0] select,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             hs;
    logic [SEL_W-1:0] arb_ptr;
    logic [SEL_W:0]   pick;
    logic             pick_vld;
    logic [SEL_W-1:0] pick_idx;

    // Returns {found, index} of the first set request scanning from p upward, mod N_REQ.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] idx;
        rr_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign hs  = out_valid & out_ready;
    assign ack = gnt & {N_REQ{hs}};

    // In BUSY the only re-arbitration happens on a handshake, where ptr becomes select+1.
    assign arb_ptr  = (state == BUSY) ? select + SEL_W'(1) : ptr;
    assign pick     = rr_pick(req, arb_ptr);
    assign pick_vld = pick[SEL_W];
    assign pick_idx = pick[SEL_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            select    <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        select    <= pick_idx;
                        gnt       <= N_REQ'(1) << pick_idx;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (hs) begin
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                        ptr      <= select + SEL_W'(1);
                        if (pick_vld) begin
                            select <= pick_idx;
                            gnt    <= N_REQ'(1) << pick_idx;
                        end else begin
                            gnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (!req[select]) begin
                        ptr       <= select + SEL_W'(1);
                        gnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mux_rr_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
        .select (select),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .in4    (in4),
        .out    (out_data)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboarded bench for mux_rr_arbiter: directed scenarios, counter wrap and random traffic.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] in1, in2, in3, in4;
    logic        out_ready;
    logic [1:0]  select;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [15:0] out_data;
    logic        out_valid;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.WIDTH(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .out_ready (out_ready),
        .select    (select),
        .gnt       (gnt),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        int          sel;
        logic [15:0] data;
        logic [3:0]  ack;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: who holds the bus (-1 when nobody), priority pointer, handshake count.
    bit model_known = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    function automatic int winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [15:0] word_of(input int i);
        case (i)
            0: return in1;
            1: return in2;
            2: return in3;
            default: return in4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus: apply inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic r, input logic [3:0] q, input logic rdy);
        exp_t e;
        int w;
        rst = r;
        req = q;
        out_ready = rdy;
        if (model_known) begin
            e.valid = (m_owner >= 0);
            e.sel   = m_owner;
            e.data  = (m_owner >= 0) ? word_of(m_owner) : 16'h0;
            e.ack   = (m_owner >= 0 && rdy) ? 4'(1 << m_owner) : 4'b0;
            e.cnt   = 16'(m_cnt);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_known = 1;
            m_owner = -1;
            m_ptr = 0;
            m_cnt = 0;
        end else if (model_known) begin
            if (m_owner < 0) begin
                m_owner = winner(q, m_ptr);
            end else if (rdy) begin
                m_cnt = (m_cnt + 1) % 65536;
                m_ptr = (m_owner + 1) % 4;
                m_owner = winner(q, m_ptr);
            end else if (!q[m_owner]) begin
                m_ptr = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end
    endtask

    // Monitor: compares the DUT's presented outputs against the queued prediction each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", 32'(out_valid), 32'(e.valid));
            check("gnt", 32'(gnt), e.valid ? 32'(1 << e.sel) : 32'h0);
            check("ack", 32'(ack), 32'(e.ack));
            check("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
            if (e.valid) begin
                check("select", 32'(select), 32'(e.sel));
                check("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 4'b0;
        out_ready = 1'b0;
        in1 = 16'd11111;
        in2 = 16'd22222;
        in3 = 16'd33333;
        in4 = 16'd44444;
        #2;

        // Reset with all requesting, then the rotation 0,1,2,3,0.
        repeat (2) step(1'b1, 4'b1111, 1'b1);
        repeat (6) step(1'b0, 4'b1111, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // Single requester for one cycle.
        step(1'b0, 4'b0100, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b1);

        // Backpressure: five stalled cycles on requester 0, then 0 and 1 served.
        repeat (6) step(1'b0, 4'b0011, 1'b0);
        step(1'b0, 4'b0011, 1'b1);
        step(1'b0, 4'b0010, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // Abort: requester 3 granted and stalled, then withdraws while 1 requests.
        repeat (2) step(1'b0, 4'b1000, 1'b0);
        repeat (2) step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // Reset while stalled on requester 2; afterwards 2 beats 3 from ptr=0.
        repeat (3) step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        repeat (3) step(1'b0, 4'b1100, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // Counter wrap: one handshake per cycle from requester 0.
        repeat (65540) step(1'b0, 4'b0001, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // Random traffic, occasional reset, changing data.
        for (int i = 0; i < 3000; i++) begin
            in1 = 16'($urandom);
            in2 = 16'($urandom);
            in3 = 16'($urandom);
            in4 = 16'($urandom);
            step(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (3) step(1'b0, 4'b0000, 1'b1);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
